// File: rtl/unpack_pkg.sv
// rtl/unpack_pkg.sv - shared types and helpers for the unpack arbiter
package unpack_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Field widths never collapse to zero bits, even for a single-value range.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_roll.sv
// rtl/counter_roll.sv - up counter that rolls over to zero after max_val_i
module counter_roll #(
  parameter int width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  input  logic [width_p-1:0] max_val_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] r_count;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (up_i) begin
      r_count <= (r_count == max_val_i) ? '0 : r_count + width_p'(1);
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/unpack_arbiter.sv
// rtl/unpack_arbiter.sv - round-robin burst arbiter feeding a registered word to the unpacker
module unpack_arbiter
  import unpack_pkg::*;
#(
  parameter  int num_req_p      = 4,
  parameter  int packed_width_p = 8,
  parameter  int burst_words_p  = 4,
  localparam int id_w_lp        = clog2_min1(num_req_p),
  localparam int cnt_w_lp       = clog2_min1(burst_words_p)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p-1:0]                valid_i,
  input  logic [num_req_p*packed_width_p-1:0] packed_i,
  output logic [num_req_p-1:0]                ready_o,
  output logic                                valid_o,
  output logic [packed_width_p-1:0]           packed_o,
  output logic [id_w_lp-1:0]                  id_o,
  output logic                                last_o,
  input  logic                                ready_i
);

  localparam logic [cnt_w_lp-1:0] max_cnt_lp = cnt_w_lp'(burst_words_p - 1);

  arb_state_e                r_state;
  arb_state_e                w_state_nxt;
  logic [id_w_lp-1:0]        r_rr_ptr;
  logic [id_w_lp-1:0]        r_grant;
  logic [id_w_lp-1:0]        w_sel;
  logic [id_w_lp-1:0]        w_grant_inc;
  logic                      w_any;
  logic                      w_ready;
  logic                      w_in_fire;
  logic                      w_out_fire;
  logic                      w_last_word;
  logic                      w_clear;
  logic [cnt_w_lp-1:0]       w_count;
  int                        w_idx;
  logic                      r_valid;
  logic [packed_width_p-1:0] r_packed;
  logic [id_w_lp-1:0]        r_id;
  logic                      r_last;

  // Walk offsets from the far end so the requester closest to rr_ptr wins.
  always_comb begin
    w_any = |valid_i;
    w_sel = '0;
    w_idx = 0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      w_idx = (int'(r_rr_ptr) + i) % num_req_p;
      if (valid_i[w_idx]) begin
        w_sel = id_w_lp'(w_idx);
      end
    end
  end

  assign w_grant_inc = (r_grant == id_w_lp'(num_req_p - 1)) ? '0 : r_grant + id_w_lp'(1);
  assign w_ready     = (r_state == BURST) && (!r_valid || ready_i);
  assign w_in_fire   = w_ready && valid_i[r_grant];
  assign w_out_fire  = r_valid && ready_i;
  assign w_last_word = (w_count == max_cnt_lp);
  assign w_clear     = (r_state == IDLE);

  always_comb begin
    ready_o = '0;
    if (w_ready) begin
      ready_o[r_grant] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_any) w_state_nxt = BURST;
      BURST: if (w_in_fire && w_last_word) w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_grant <= w_sel;
      end
      if (w_in_fire && w_last_word) begin
        r_rr_ptr <= w_grant_inc;
      end
    end
  end

  // A new word may replace the current one in the same cycle it is consumed.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_valid  <= 1'b0;
      r_packed <= '0;
      r_id     <= '0;
      r_last   <= 1'b0;
    end else if (w_in_fire) begin
      r_valid  <= 1'b1;
      r_packed <= packed_i[r_grant*packed_width_p +: packed_width_p];
      r_id     <= r_grant;
      r_last   <= w_last_word;
    end else if (w_out_fire) begin
      r_valid  <= 1'b0;
    end
  end

  counter_roll #(
    .width_p (cnt_w_lp)
  ) u_burst_cnt (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (w_clear),
    .up_i      (w_in_fire),
    .max_val_i (max_cnt_lp),
    .count_o   (w_count)
  );

  assign valid_o  = r_valid;
  assign packed_o = r_packed;
  assign id_o     = r_id;
  assign last_o   = r_last;

endmodule

// File: tb/tb_unpack_arbiter.sv
// tb/tb_unpack_arbiter.sv - self-checking bench for unpack_arbiter
module tb_unpack_arbiter;

  localparam int NR = 4;
  localparam int PW = 8;
  localparam int BW = 4;

  logic            clk_i    = 1'b0;
  logic            reset_i  = 1'b1;
  logic [NR-1:0]   valid_i  = '0;
  logic [NR*PW-1:0] packed_i = '0;
  logic            ready_i  = 1'b0;
  logic [NR-1:0]   ready_o;
  logic            valid_o;
  logic [PW-1:0]   packed_o;
  logic [1:0]      id_o;
  logic            last_o;

  int n_chk  = 0;
  int n_fail = 0;

  int burst_ids[$];
  int burst_lens[$];
  int run_words = 0;

  // Behavioural model: a burst is "words_left" transfers from one owner.
  bit        m_busy  = 1'b0;
  bit        m_valid = 1'b0;
  bit        m_last  = 1'b0;
  int        m_g     = 0;
  int        m_left  = 0;
  int        m_rr    = 0;
  int        m_id    = 0;
  logic [7:0] m_data = '0;

  typedef struct {
    logic [3:0] v;
    logic       r;
    logic [3:0] er;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] eid;
    logic       el;
  } vec_t;

  vec_t tbl[15];

  unpack_arbiter #(
    .num_req_p      (NR),
    .packed_width_p (PW),
    .burst_words_p  (BW)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .valid_i  (valid_i),
    .packed_i (packed_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .packed_o (packed_o),
    .id_o     (id_o),
    .last_o   (last_o),
    .ready_i  (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rdy;
    bit fin;
    bit fout;
    bit was_busy;
    bit found;
    int k;
    if (reset_i) begin
      m_busy = 0; m_valid = 0; m_last = 0; m_g = 0; m_left = 0;
      m_rr = 0; m_id = 0; m_data = '0;
      return;
    end
    was_busy = m_busy;
    rdy  = m_busy && (!m_valid || ready_i);
    fin  = rdy && valid_i[m_g];
    fout = m_valid && ready_i;
    if (fin) begin
      m_valid = 1;
      m_data  = packed_i[m_g*PW +: PW];
      m_id    = m_g;
      m_last  = (m_left == 1);
      m_left  = m_left - 1;
      if (m_left == 0) begin
        m_busy = 0;
        m_rr   = (m_g + 1) % NR;
      end
    end else if (fout) begin
      m_valid = 0;
    end
    if (!was_busy && valid_i != 0) begin
      found = 0;
      for (int i = 0; i < NR; i++) begin
        k = (m_rr + i) % NR;
        if (!found && valid_i[k]) begin
          m_g   = k;
          found = 1;
        end
      end
      m_busy = 1;
      m_left = BW;
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    model_step();
  end

  // Per-cycle comparison against the model, plus burst bookkeeping.
  initial forever begin
    logic [3:0] exp_rdy;
    @(negedge clk_i);
    #3;
    if (reset_i) begin
      run_words = 0;
    end else begin
      exp_rdy = (m_busy && (!m_valid || ready_i)) ? (4'b0001 << m_g) : 4'b0000;
      check("model_ready_o", 32'(ready_o), 32'(exp_rdy));
      check("model_valid_o", 32'(valid_o), 32'(m_valid));
      if (m_valid) begin
        check("model_packed_o", 32'(packed_o), 32'(m_data));
        check("model_id_o", 32'(id_o), 32'(m_id));
        check("model_last_o", 32'(last_o), 32'(m_last));
      end
      if (valid_o && ready_i) begin
        run_words++;
        if (last_o) begin
          burst_ids.push_back(int'(id_o));
          burst_lens.push_back(run_words);
          run_words = 0;
        end
      end
    end
  end

  task automatic drive(input logic [3:0] v, input logic r, input int n);
    repeat (n) begin
      @(negedge clk_i);
      #1;
      valid_i  = v;
      ready_i  = r;
      packed_i = $urandom;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #1;
    reset_i = 1'b1;
    valid_i = '0;
    ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    reset_i = 1'b0;
    burst_ids.delete();
    burst_lens.delete();
  endtask

  task automatic check_ids(input string name, input int exp[5], input int n);
    for (int i = 0; i < n; i++) begin
      if (i < burst_ids.size()) begin
        check($sformatf("%s_id%0d", name, i), burst_ids[i], exp[i]);
      end else begin
        check($sformatf("%s_missing%0d", name, i), 32'(burst_ids.size()), 32'(i + 1));
      end
    end
  endtask

  initial begin
    int exp_ids[5];

    tbl[0]  = '{4'b0001, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[1]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[2]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'h01, 2'd0, 1'b0};
    tbl[3]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'h02, 2'd0, 1'b0};
    tbl[4]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'h03, 2'd0, 1'b0};
    tbl[5]  = '{4'b0001, 1'b1, 4'b0000, 1'b1, 8'h04, 2'd0, 1'b1};
    tbl[6]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[7]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'h06, 2'd0, 1'b0};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0001, 1'b1, 8'h07, 2'd0, 1'b0};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[10] = '{4'b0001, 1'b0, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[11] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 8'h0A, 2'd0, 1'b0};
    tbl[12] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 8'h0A, 2'd0, 1'b0};
    tbl[13] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'h0A, 2'd0, 1'b0};
    tbl[14] = '{4'b0001, 1'b1, 4'b0000, 1'b1, 8'h0D, 2'd0, 1'b1};

    repeat (2) @(negedge clk_i);
    #1;
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd0);
    check("rst_packed_o", 32'(packed_o), 32'd0);
    check("rst_id_o", 32'(id_o), 32'd0);
    check("rst_last_o", 32'(last_o), 32'd0);
    reset_i = 1'b0;

    // Single requester: latency, back-to-back burst, bubble, stalls.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      #1;
      valid_i = tbl[i].v;
      ready_i = tbl[i].r;
      for (int k = 0; k < NR; k++) packed_i[k*PW +: PW] = {2'(k), 6'(i)};
      #1;
      check($sformatf("tbl%0d_ready_o", i), 32'(ready_o), 32'(tbl[i].er));
      check($sformatf("tbl%0d_valid_o", i), 32'(valid_o), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d_packed_o", i), 32'(packed_o), 32'(tbl[i].ed));
        check($sformatf("tbl%0d_id_o", i), 32'(id_o), 32'(tbl[i].eid));
        check($sformatf("tbl%0d_last_o", i), 32'(last_o), 32'(tbl[i].el));
      end
    end

    // All requesters valid: strict rotation.
    do_reset();
    drive(4'b1111, 1'b1, 30);
    exp_ids = '{0, 1, 2, 3, 0};
    check_ids("all_valid", exp_ids, 5);
    for (int i = 0; i < 4 && i < burst_lens.size(); i++)
      check($sformatf("all_valid_len%0d", i), burst_lens[i], BW);

    // Wrap: pointer at 3 with requesters 0 and 2 pending.
    do_reset();
    drive(4'b0100, 1'b1, 2);
    drive(4'b0101, 1'b1, 18);
    exp_ids = '{2, 0, 2, 0, 0};
    check_ids("wrap", exp_ids, 3);

    // Granted requester drops valid mid-burst while others wait.
    do_reset();
    drive(4'b1111, 1'b1, 3);
    drive(4'b1110, 1'b1, 3);
    drive(4'b1111, 1'b1, 12);
    exp_ids = '{0, 1, 0, 0, 0};
    check_ids("stall", exp_ids, 2);
    if (burst_lens.size() > 0) check("stall_len0", burst_lens[0], BW);

    // Downstream backpressure alternating every cycle.
    do_reset();
    drive(4'b0001, 1'b1, 2);
    for (int i = 0; i < 16; i++) drive(4'b0001, (i % 2 == 0) ? 1'b0 : 1'b1, 1);
    drive(4'b0000, 1'b1, 6);
    check("bp_bursts", 32'(burst_ids.size() >= 1), 32'd1);

    // Asynchronous reset after the second word leaves.
    do_reset();
    drive(4'b0001, 1'b1, 4);
    @(negedge clk_i);
    #1;
    reset_i = 1'b1;
    #1;
    check("midrst_valid_o", 32'(valid_o), 32'd0);
    check("midrst_ready_o", 32'(ready_o), 32'd0);
    check("midrst_last_o", 32'(last_o), 32'd0);
    @(negedge clk_i);
    #1;
    valid_i = '0;
    @(negedge clk_i);
    #1;
    reset_i = 1'b0;
    burst_ids.delete();
    burst_lens.delete();
    drive(4'b0010, 1'b1, 8);
    exp_ids = '{1, 0, 0, 0, 0};
    check_ids("midrst", exp_ids, 1);
    if (burst_lens.size() > 0) check("midrst_len", burst_lens[0], BW);
    else check("midrst_len_missing", 32'(burst_lens.size()), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1);
    end
    drive(4'b0000, 1'b1, 8);
    check("rand_bursts_seen", 32'(burst_ids.size() > 10), 32'd1);
    for (int i = 0; i < burst_lens.size(); i++) begin
      if (burst_lens[i] != BW) check($sformatf("rand_len%0d", i), burst_lens[i], BW);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
